cpu_console: RTL and testbench

//  Parametrised front-panel CPU: an operator steps through opcode, source A and source B

---
 rtl/cpu_console_pkg.sv | 53 +++++
 rtl/cpu_console_seg7_hex.sv | 13 +
 rtl/cpu_console.sv | 190 +++++++++++++++++++
 tb/tb_cpu_console.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_console_pkg.sv
// Shared types and constants for the front-panel console CPU: FSM states, opcodes, 7-segment glyphs.
// Latency: n/a (declarations only). Backpressure: n/a.
// Segment vectors are [1:7] = a..g, active-low.
package cpu_console_pkg;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_RA   = 3'd1,
        S_RB   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;

    localparam logic [1:7] SEG_BLANK = 7'b1111111;
    localparam logic [1:7] SEG_o     = 7'b1100010;
    localparam logic [1:7] SEG_P     = 7'b0011000;
    localparam logic [1:7] SEG_r     = 7'b1111010;
    localparam logic [1:7] SEG_A     = 7'b0001000;
    localparam logic [1:7] SEG_b     = 7'b1100000;

    function automatic logic [1:7] hex_to_seg(input logic [3:0] nib);
        logic [1:7] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/cpu_console_seg7_hex.sv
// Hex nibble to active-low 7-segment decoder.
// Latency: combinational. Backpressure: none.
// One instance per displayed hex digit.
module seg7_hex
    import cpu_console_pkg::*;
(
    input  logic [3:0] nib,
    output logic [1:7] seg
);

    assign seg = hex_to_seg(nib);

endmodule

// File: rtl/cpu_console.sv
// Front-panel CPU: button-stepped opcode/regA/regB entry, ALU on a register file, result on 4x 7-seg.
// Latency: press ~3 cycles after button falls (plus DEBOUNCE_CYCLES with CPU_CONSOLE_DEBOUNCE_EN); display registered +1.
// Backpressure: none; presses outside S_OP/S_RA/S_RB/S_SHOW are dropped.
module cpu_console
    import cpu_console_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int NUM_REGS        = 8,
    parameter int SW_W            = 4,
    parameter int INIT_VAL        = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [SW_W-1:0] inputs,
    input  logic            setButton,
    output logic [1:7]      leds3,
    output logic [1:7]      leds2,
    output logic [1:7]      leds1,
    output logic [1:7]      leds0,
    output logic [2:0]      state
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // Button path: the idle (released) level is 1, so sync flops reset high.
    logic btn_s1, btn_s2, btn_lvl, btn_prev, press;

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
        end else begin
            btn_s1 <= setButton;
            btn_s2 <= btn_s1;
        end
    end

`ifdef CPU_CONSOLE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] deb_cnt;
    logic             deb_lvl;

    always_ff @(posedge clock) begin
        if (reset) begin
            deb_cnt <= '0;
            deb_lvl <= 1'b1;
        end else if (btn_s2 != deb_lvl) begin
            if (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_lvl <= btn_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign btn_lvl = deb_lvl;
`else
    assign btn_lvl = btn_s2;
`endif

    always_ff @(posedge clock) begin
        if (reset) btn_prev <= 1'b1;
        else       btn_prev <= btn_lvl;
    end

    assign press = btn_prev & ~btn_lvl;

    // FSM
    state_t state_q, state_d;

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_OP;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OP:    if (press) state_d = S_RA;
            S_RA:    if (press) state_d = S_RB;
            S_RB:    if (press) state_d = S_EXEC;
            S_EXEC:  state_d = S_SHOW;
            S_SHOW:  if (press) state_d = S_OP;
            default: state_d = S_OP;
        endcase
    end

    assign state = state_q;

    // Register file and operand latches
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [SW_W-1:0]   op_code;
    logic [IDX_W-1:0]  id_a, id_b;
    logic [DATA_W-1:0] result_q, alu_r, op_a, op_b;
    logic              alu_we;
    logic [15:0]       op_ext;

    assign op_ext = 16'(op_code);
    assign op_a   = regs[id_a];
    assign op_b   = regs[id_b];

    always_comb begin
        alu_r  = op_a;
        alu_we = 1'b1;
        case (op_ext)
            {12'd0, OP_ADD}: alu_r = op_a + op_b;
            {12'd0, OP_SUB}: alu_r = op_a - op_b;
            {12'd0, OP_AND}: alu_r = op_a & op_b;
            {12'd0, OP_OR }: alu_r = op_a | op_b;
            {12'd0, OP_XOR}: alu_r = op_a ^ op_b;
            {12'd0, OP_MOV}: alu_r = op_b;
            {12'd0, OP_SHL}: alu_r = {op_a[DATA_W-2:0], 1'b0};
            {12'd0, OP_SHR}: alu_r = {1'b0, op_a[DATA_W-1:1]};
            default:         alu_we = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_code  <= '0;
            id_a     <= '0;
            id_b     <= '0;
            result_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_W'(INIT_VAL);
        end else begin
            if (press && state_q == S_OP) op_code <= inputs;
            if (press && state_q == S_RA) id_a    <= inputs[IDX_W-1:0];
            if (press && state_q == S_RB) id_b    <= inputs[IDX_W-1:0];
            if (state_q == S_EXEC) begin
                result_q <= alu_r;
                if (alu_we) regs[id_a] <= alu_r;
            end
        end
    end

    // Display: one decoder for the field digit, four for the result
    logic [15:0] ida_ext, idb_ext, res_ext;
    logic [3:0]  fld_nib;
    logic [1:7]  fld_seg, res_seg3, res_seg2, res_seg1, res_seg0;
    logic [1:7]  nxt3, nxt2, nxt1, nxt0;

    assign ida_ext = 16'(id_a);
    assign idb_ext = 16'(id_b);
    assign res_ext = 16'(result_q);

    always_comb begin
        fld_nib = op_ext[3:0];
        if (state_q == S_RA) fld_nib = ida_ext[3:0];
        if (state_q == S_RB) fld_nib = idb_ext[3:0];
    end

    seg7_hex u_fld  (.nib(fld_nib),        .seg(fld_seg));
    seg7_hex u_res3 (.nib(res_ext[15:12]), .seg(res_seg3));
    seg7_hex u_res2 (.nib(res_ext[11:8]),  .seg(res_seg2));
    seg7_hex u_res1 (.nib(res_ext[7:4]),   .seg(res_seg1));
    seg7_hex u_res0 (.nib(res_ext[3:0]),   .seg(res_seg0));

    always_comb begin
        nxt3 = leds3;
        nxt2 = leds2;
        nxt1 = leds1;
        nxt0 = leds0;
        case (state_q)
            S_OP:   begin nxt3 = SEG_o; nxt2 = SEG_P; nxt1 = SEG_BLANK; nxt0 = fld_seg; end
            S_RA:   begin nxt3 = SEG_r; nxt2 = SEG_A; nxt1 = SEG_BLANK; nxt0 = fld_seg; end
            S_RB:   begin nxt3 = SEG_r; nxt2 = SEG_b; nxt1 = SEG_BLANK; nxt0 = fld_seg; end
            S_SHOW: begin nxt3 = res_seg3; nxt2 = res_seg2; nxt1 = res_seg1; nxt0 = res_seg0; end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            leds3 <= SEG_BLANK;
            leds2 <= SEG_BLANK;
            leds1 <= SEG_BLANK;
            leds0 <= SEG_BLANK;
        end else begin
            leds3 <= nxt3;
            leds2 <= nxt2;
            leds1 <= nxt1;
            leds0 <= nxt0;
        end
    end

endmodule

// File: tb/tb_cpu_console.sv
// Randomized bench for cpu_console against a behavioural model of the console CPU.
module tb_cpu_console;

    localparam int HOLD = 24;
    localparam int REL  = 24;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] inputs;
    logic       setButton;
    logic [1:7] leds3, leds2, leds1, leds0;
    logic [2:0] state;

    cpu_console dut (
        .clock(clock), .reset(reset), .inputs(inputs), .setButton(setButton),
        .leds3(leds3), .leds2(leds2), .leds1(leds1), .leds0(leds0), .state(state)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Active-low a..g glyphs, a is the leftmost bit
    logic [6:0] hex_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    localparam logic [6:0] G_BL = 7'b1111111;
    localparam logic [6:0] G_O  = 7'b1100010;
    localparam logic [6:0] G_P  = 7'b0011000;
    localparam logic [6:0] G_R  = 7'b1111010;
    localparam logic [6:0] G_A  = 7'b0001000;
    localparam logic [6:0] G_B  = 7'b1100000;

    // Reference model
    int m_state, m_op, m_ida, m_idb, m_r;
    int m_regs [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_op = 0; m_ida = 0; m_idb = 0; m_r = 0;
        for (int i = 0; i < 8; i++) m_regs[i] = 1;
    endtask

    task automatic model_press(input int val);
        int a, b;
        case (m_state)
            0: begin m_op = val; m_state = 1; end
            1: begin m_ida = val % 8; m_state = 2; end
            2: begin
                m_idb = val % 8;
                a = m_regs[m_ida];
                b = m_regs[m_idb];
                case (m_op)
                    0: m_r = (a + b) % 256;
                    1: m_r = (a - b + 256) % 256;
                    2: m_r = a & b;
                    3: m_r = a | b;
                    4: m_r = a ^ b;
                    5: m_r = b;
                    6: m_r = (a * 2) % 256;
                    7: m_r = a / 2;
                    default: m_r = a;
                endcase
                if (m_op < 8) m_regs[m_ida] = m_r;
                m_state = 4;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic check_display(input string tag);
        logic [6:0] e3, e2, e1, e0;
        case (m_state)
            0: begin e3 = G_O; e2 = G_P; e1 = G_BL; e0 = hex_tab[m_op % 16]; end
            1: begin e3 = G_R; e2 = G_A; e1 = G_BL; e0 = hex_tab[m_ida]; end
            2: begin e3 = G_R; e2 = G_B; e1 = G_BL; e0 = hex_tab[m_idb]; end
            default: begin
                e3 = hex_tab[(m_r >> 12) % 16]; e2 = hex_tab[(m_r >> 8) % 16];
                e1 = hex_tab[(m_r >> 4) % 16];  e0 = hex_tab[m_r % 16];
            end
        endcase
        check({tag, ".state"}, 32'(state), 32'(m_state));
        check({tag, ".leds3"}, 32'(leds3), 32'(e3));
        check({tag, ".leds2"}, 32'(leds2), 32'(e2));
        check({tag, ".leds1"}, 32'(leds1), 32'(e1));
        check({tag, ".leds0"}, 32'(leds0), 32'(e0));
    endtask

    // Hold the button low for 'hold' cycles with inputs=val, release, then compare with the model
    task automatic press(input int val, input int hold, input string tag);
        int exec_cnt;
        int exp_exec;
        exec_cnt = 0;
        exp_exec = (m_state == 2) ? 1 : 0;
        inputs = 4'(val);
        setButton = 1'b0;
        repeat (hold) begin
            @(negedge clock);
            if (state == 3'd3) exec_cnt++;
        end
        setButton = 1'b1;
        repeat (REL) begin
            @(negedge clock);
            if (state == 3'd3) exec_cnt++;
        end
        model_press(val);
        check({tag, ".exec_cycles"}, 32'(exec_cnt), 32'(exp_exec));
        check_display(tag);
    endtask

    task automatic run_seq(input int op, input int a, input int b, input string tag);
        press(op, HOLD, {tag, ".op"});
        press(a,  HOLD, {tag, ".ra"});
        press(b,  HOLD, {tag, ".rb"});
        press(0,  HOLD, {tag, ".back"});
    endtask

    initial begin
        reset = 1'b1;
        setButton = 1'b1;
        inputs = 4'd0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset.state", 32'(state), 32'd0);
        check("reset.leds3", 32'(leds3), 32'(G_BL));
        check("reset.leds2", 32'(leds2), 32'(G_BL));
        check("reset.leds1", 32'(leds1), 32'(G_BL));
        check("reset.leds0", 32'(leds0), 32'(G_BL));
        reset = 1'b0;
        @(negedge clock);
        check_display("post_reset");

        // ADD r2 = r2 + r3 = 2
        press(0, HOLD, "add.op");
        press(2, HOLD, "add.ra");
        press(3, HOLD, "add.rb");
        check("add.r", 32'(m_r), 32'h2);
        press(0, HOLD, "add.back");

        // SUB to zero, then 0 - 1 wraps to FF
        run_seq(1, 1, 1, "sub_zero");
        press(1, HOLD, "wrap.op");
        press(1, HOLD, "wrap.ra");
        press(0, HOLD, "wrap.rb");
        check("wrap.r", 32'(m_r), 32'hFF);
        press(0, HOLD, "wrap.back");

        // NOP with truncated ids: A=0xA -> reg 2, B=0xF -> reg 7
        run_seq(9, 10, 15, "nop_trunc");

        // Mid-sequence reset from S_RB
        press(5, HOLD, "mid.op");
        press(3, HOLD, "mid.ra");
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_reset.state", 32'(state), 32'd0);
        check("mid_reset.leds3", 32'(leds3), 32'(G_BL));
        check("mid_reset.leds0", 32'(leds0), 32'(G_BL));
        model_reset();
        @(negedge clock);
        check_display("mid_reset.next");
        run_seq(9, 2, 0, "mid_reset.reg2");
        run_seq(9, 1, 0, "mid_reset.reg1");

        // Long hold: exactly one advance
        press(3, 100, "long_hold");
        press(4, HOLD, "long_hold.ra");
        press(6, HOLD, "long_hold.rb");
        press(0, HOLD, "long_hold.back");

`ifdef CPU_CONSOLE_DEBOUNCE_EN
        setButton = 1'b0;
        repeat (5) @(negedge clock);
        setButton = 1'b1;
        repeat (30) @(negedge clock);
        check_display("glitch");
`endif

        // Random sequences
        for (int k = 0; k < 25; k++) begin
            run_seq($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
